// File: rtl/msg_reg_uart_tx_if.sv
// Handshake/serial bundle between the message-register UART block and its host.
interface msg_reg_uart_tx_if;
  logic       ready;
  logic [7:0] data;
  logic       blue;
  logic       tx_ctrl;
  logic [7:0] tx_byte;
  logic       transmit_ready;
  logic       tx_serial;

  modport master (
    output ready, data,
    input  blue, tx_ctrl, tx_byte, transmit_ready, tx_serial
  );

  modport slave (
    input  ready, data,
    output blue, tx_ctrl, tx_byte, transmit_ready, tx_serial
  );
endinterface

// File: rtl/msg_reg_uart_tx.sv
// One-deep message register feeding an 8N1 UART transmitter.
// A rising edge of ready captures data; the byte launches whenever the UART is idle.
module msg_reg (
  input  logic       clk,
  input  logic       nRst,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       transmit_ready,
  output logic       pending,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte
);
  logic       ready_d;
  logic [7:0] msg;

  // Capture needs pending=0 and launch needs pending=1, so they never collide.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ready_d <= 1'b0;
      pending <= 1'b0;
      msg     <= '0;
      tx_ctrl <= 1'b0;
      tx_byte <= '0;
    end else begin
      ready_d <= ready;
      if (ready && !ready_d && !pending) begin
        msg     <= data;
        pending <= 1'b1;
      end
      if (pending && transmit_ready && !tx_ctrl) begin
        tx_ctrl <= 1'b1;
        tx_byte <= msg;
        pending <= 1'b0;
      end else begin
        tx_ctrl <= 1'b0;
      end
    end
  end
endmodule

module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       tx_ctrl,
  input  logic [7:0] tx_byte,
  output logic       transmit_ready,
  output logic       tx_serial
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      tx_serial      <= 1'b1;
      transmit_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tx_ctrl) begin
            shreg          <= tx_byte;
            transmit_ready <= 1'b0;
            tx_serial      <= 1'b0;
            clk_cnt        <= '0;
            state          <= START;
          end
        end
        START: begin
          if (clk_cnt == LAST) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            tx_serial <= shreg[0];
            state     <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_serial <= 1'b1;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shreg[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == LAST) begin
            clk_cnt        <= '0;
            transmit_ready <= 1'b1;
            state          <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module msg_reg_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic               clk,
  input  logic               nRst,
  msg_reg_uart_tx_if.slave   bus
);
  logic pending;

  msg_reg u_msg_reg (
    .clk            (clk),
    .nRst           (nRst),
    .ready          (bus.ready),
    .data           (bus.data),
    .transmit_ready (bus.transmit_ready),
    .pending        (pending),
    .tx_ctrl        (bus.tx_ctrl),
    .tx_byte        (bus.tx_byte)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .clk            (clk),
    .nRst           (nRst),
    .tx_ctrl        (bus.tx_ctrl),
    .tx_byte        (bus.tx_byte),
    .transmit_ready (bus.transmit_ready),
    .tx_serial      (bus.tx_serial)
  );

  assign bus.blue = pending | bus.tx_ctrl | ~bus.transmit_ready;
endmodule

// File: tb/tb_msg_reg_uart_tx.sv
// Bench for msg_reg_uart_tx: a line monitor decodes frames; scenario tasks compare
// decoded bytes, frame timing and status pins against expectations built from the byte stream.
module tb_msg_reg_uart_tx;
  localparam int CPB = 10;

  logic tb_clk = 1'b0;
  logic nRst   = 1'b0;
  longint cyc  = 0;
  int passed   = 0;
  int total    = 0;

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  msg_reg_uart_tx_if bus ();

  msg_reg_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (tb_clk),
    .nRst (nRst),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       shape_ok;
    logic       tr_ok;
    int         low_cnt;
    longint     start_cyc;
  } frame_t;

  frame_t frame_q[$];

  // Line monitor: records every complete frame seen on tx_serial.
  initial begin : monitor
    logic   prev;
    logic   lvl [10*CPB];
    logic   aborted;
    logic   tr_bad;
    frame_t f;
    prev = 1'b1;
    forever begin
      @(negedge tb_clk);
      if (nRst === 1'b1 && prev === 1'b1 && bus.tx_serial === 1'b0) begin
        f.start_cyc = cyc;
        aborted = 1'b0;
        tr_bad  = (bus.transmit_ready !== 1'b0);
        lvl[0]  = bus.tx_serial;
        for (int i = 1; i < 10*CPB && !aborted; i++) begin
          @(negedge tb_clk);
          if (nRst !== 1'b1) aborted = 1'b1;
          else begin
            lvl[i] = bus.tx_serial;
            if (bus.transmit_ready !== 1'b0) tr_bad = 1'b1;
          end
        end
        if (!aborted) begin
          @(negedge tb_clk);
          if (nRst !== 1'b1) aborted = 1'b1;
          else if (bus.transmit_ready !== 1'b1) tr_bad = 1'b1;
        end
        if (!aborted) begin
          f.shape_ok = (lvl[0] === 1'b0) && (lvl[9*CPB] === 1'b1);
          f.low_cnt  = 0;
          for (int bt = 0; bt < 10; bt++)
            for (int c = 0; c < CPB; c++) begin
              if (lvl[bt*CPB+c] !== lvl[bt*CPB]) f.shape_ok = 1'b0;
              if (lvl[bt*CPB+c] === 1'b0) f.low_cnt++;
            end
          for (int k = 0; k < 8; k++) f.b[k] = lvl[(k+1)*CPB];
          f.tr_ok = !tr_bad;
          frame_q.push_back(f);
        end
      end
      prev = bus.tx_serial;
    end
  end

  function automatic int zeros_of(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) if (v[k] == 1'b0) n++;
    return n;
  endfunction

  task automatic send_pulse(input logic [7:0] d);
    bus.data  = d;
    bus.ready = 1'b1;
    @(negedge tb_clk);
    bus.ready = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int c = 0;
    while (frame_q.size() < n && c < budget) begin
      @(negedge tb_clk);
      c++;
    end
    total++;
    if (frame_q.size() < n)
      $display("FAIL %s: timeout, frames seen %0d, required %0d", name, frame_q.size(), n);
    else passed++;
  endtask

  task automatic check_frame(input int idx, input logic [7:0] exp_b, input string name);
    frame_t f;
    f = frame_q[idx];
    total++;
    if (f.b !== exp_b) $display("FAIL %s byte: got %h, required %h", name, f.b, exp_b);
    else passed++;
    total++;
    if (f.shape_ok !== 1'b1 || f.low_cnt != CPB*(1 + zeros_of(exp_b)))
      $display("FAIL %s shape: shape_ok=%0b low cycles %0d, required 1 and %0d",
               name, f.shape_ok, f.low_cnt, CPB*(1 + zeros_of(exp_b)));
    else passed++;
    total++;
    if (f.tr_ok !== 1'b1) $display("FAIL %s transmit_ready window: got %0b, required 1", name, f.tr_ok);
    else passed++;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    bus.ready = 1'b0;
    bus.data  = '0;
    repeat (3) @(negedge tb_clk);
    nRst = 1'b1;
    repeat (2) @(negedge tb_clk);
    total++; if (bus.tx_serial !== 1'b1) $display("FAIL reset tx_serial: got %b, required 1", bus.tx_serial); else passed++;
    total++; if (bus.transmit_ready !== 1'b1) $display("FAIL reset transmit_ready: got %b, required 1", bus.transmit_ready); else passed++;
    total++; if (bus.blue !== 1'b0) $display("FAIL reset blue: got %b, required 0", bus.blue); else passed++;
    total++; if (bus.tx_ctrl !== 1'b0) $display("FAIL reset tx_ctrl: got %b, required 0", bus.tx_ctrl); else passed++;
    total++; if (bus.tx_byte !== 8'h00) $display("FAIL reset tx_byte: got %h, required 00", bus.tx_byte); else passed++;
  endtask

  task automatic test_single();
    frame_q.delete();
    send_pulse(8'h0A);
    total++; if (bus.blue !== 1'b1 || bus.tx_ctrl !== 1'b0)
      $display("FAIL single capture: blue=%b tx_ctrl=%b, required 1 0", bus.blue, bus.tx_ctrl); else passed++;
    @(negedge tb_clk);
    total++; if (bus.tx_ctrl !== 1'b1 || bus.tx_byte !== 8'h0A)
      $display("FAIL single launch: tx_ctrl=%b tx_byte=%h, required 1 0a", bus.tx_ctrl, bus.tx_byte); else passed++;
    @(negedge tb_clk);
    total++; if (bus.tx_ctrl !== 1'b0 || bus.tx_serial !== 1'b0 || bus.transmit_ready !== 1'b0)
      $display("FAIL single start: tx_ctrl=%b tx_serial=%b transmit_ready=%b, required 0 0 0",
               bus.tx_ctrl, bus.tx_serial, bus.transmit_ready); else passed++;
    wait_frames(1, 12*CPB, "single wait");
    if (frame_q.size() >= 1) check_frame(0, 8'h0A, "single");
    @(negedge tb_clk);
    total++; if (bus.blue !== 1'b0) $display("FAIL single blue after frame: got %b, required 0", bus.blue); else passed++;
  endtask

  task automatic test_hold();
    frame_q.delete();
    bus.data  = 8'h55;
    bus.ready = 1'b1;
    repeat (50) @(negedge tb_clk);
    bus.ready = 1'b0;
    wait_frames(1, 12*CPB, "hold wait");
    repeat (15*CPB) @(negedge tb_clk);
    total++; if (frame_q.size() != 1) $display("FAIL hold frame count: got %0d, required 1", frame_q.size()); else passed++;
    if (frame_q.size() >= 1) check_frame(0, 8'h55, "hold");
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1, r3;
    longint gap;
    frame_q.delete();
    r1 = 8'($urandom);
    r3 = 8'($urandom);
    if (r3 == 8'hC3) r3 = 8'h3C;
    send_pulse(r1);
    repeat (30) @(negedge tb_clk);
    send_pulse(8'hC3);
    repeat (10) @(negedge tb_clk);
    send_pulse(r3);
    wait_frames(2, 25*CPB, "b2b wait");
    repeat (15*CPB) @(negedge tb_clk);
    total++; if (frame_q.size() != 2) $display("FAIL b2b frame count: got %0d, required 2", frame_q.size()); else passed++;
    if (frame_q.size() >= 2) begin
      check_frame(0, r1, "b2b first");
      check_frame(1, 8'hC3, "b2b second");
      gap = frame_q[1].start_cyc - frame_q[0].start_cyc;
      total++;
      if (gap < 10*CPB + 1 || gap > 10*CPB + 2)
        $display("FAIL b2b start spacing: got %0d cycles, required %0d..%0d", gap, 10*CPB+1, 10*CPB+2);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    frame_q.delete();
    send_pulse(8'($urandom));
    while (bus.tx_serial !== 1'b0 && c < 10) begin
      @(negedge tb_clk);
      c++;
    end
    total++; if (bus.tx_serial !== 1'b0) $display("FAIL midreset start not seen: tx_serial=%b, required 0", bus.tx_serial); else passed++;
    repeat (5*CPB + 3) @(negedge tb_clk);
    #2 nRst = 1'b0;
    #1;
    total++; if (bus.tx_serial !== 1'b1 || bus.transmit_ready !== 1'b1 || bus.blue !== 1'b0)
      $display("FAIL midreset async: tx_serial=%b transmit_ready=%b blue=%b, required 1 1 0",
               bus.tx_serial, bus.transmit_ready, bus.blue); else passed++;
    repeat (2) @(negedge tb_clk);
    nRst = 1'b1;
    repeat (20*CPB) @(negedge tb_clk);
    total++; if (frame_q.size() != 0 || bus.blue !== 1'b0)
      $display("FAIL midreset residual: frames=%0d blue=%b, required 0 0", frame_q.size(), bus.blue); else passed++;
  endtask

  task automatic test_extremes();
    frame_q.delete();
    send_pulse(8'hFF);
    repeat (5) @(negedge tb_clk);
    send_pulse(8'h00);
    wait_frames(2, 25*CPB, "extremes wait");
    if (frame_q.size() >= 2) begin
      check_frame(0, 8'hFF, "ff");
      check_frame(1, 8'h00, "00");
    end
    repeat (3) @(negedge tb_clk);
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 4; n++) begin
      frame_q.delete();
      v = 8'($urandom);
      repeat ($urandom_range(1, 5)) @(negedge tb_clk);
      send_pulse(v);
      wait_frames(1, 12*CPB, "random wait");
      if (frame_q.size() >= 1) check_frame(0, v, "random");
    end
  endtask

  initial begin
    bus.ready = 1'b0;
    bus.data  = '0;
    @(negedge tb_clk);
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_extremes();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
